// File: rtl/mod29_sink_pkg.sv
// Shared types for the mod29 result sink.
//   sample_t : packed {b32, v33[2:0], b34}, b32 is the MSB
//   SAMPLE_W : width of one packed sample
//   state_t  : run-length encoder state (no open run / run open)
package mod29_sink_pkg;

  localparam int unsigned SAMPLE_W = 5;

  typedef struct packed {
    logic       b32;
    logic [2:0] v33;
    logic       b34;
  } sample_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage : mod29_sink_pkg

// File: rtl/mod29_sink_fifo.sv
// Parameterized synchronous FIFO with first-word-fall-through read port.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (pointers only)
//   push, wdata   : write request and data (ignored while full)
//   pop           : read request (ignored while empty)
//   rdata         : head entry, combinational from storage
//   full, empty   : occupancy flags from registered pointers
//   level         : current occupancy, 0..DEPTH
// DEPTH must be a power of 2, at least 2.
module mod29_sink_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = LW'(wr_ptr - rd_ptr);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in one cycle move both and keep the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule : mod29_sink_fifo

// File: rtl/mod29_result_sink.sv
// Run-length encoding sink for the mod29 result outputs.
// Qualified samples {in_b32, in_v33, in_b34} are collapsed into records
// {sample, run length}, buffered in a small FIFO and offered on a
// valid/ready port. Upstream is throttled through in_ready (= FIFO not full),
// so no record is ever lost.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid, in_ready         : sample qualifier / sink can accept
//   in_b32, in_v33, in_b34     : mod29 pob32, pov33_2, pob34
//   flush                      : close the open run and emit it
//   out_valid, out_ready       : record handshake
//   out_data                   : {sample[4:0], cnt[CNT_W-1:0]}
//   fifo_level                 : FIFO occupancy
//   rec_count (optional)       : 16-bit wrapping count of pushed records,
//                                present only when MOD29_SINK_STATS_EN is defined
module mod29_result_sink
  import mod29_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_b32,
  input  logic [2:0]                  in_v33,
  input  logic                        in_b34,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SAMPLE_W+CNT_W-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level
`ifdef MOD29_SINK_STATS_EN
  ,
  output logic [15:0]                 rec_count
`endif
);

  localparam int unsigned REC_W = SAMPLE_W + CNT_W;
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    sample_t          sample;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  state_t           state;
  sample_t          cur;
  logic [CNT_W-1:0] cnt;
  sample_t          sample;
  logic             full;
  logic             empty;
  logic             acc_s;
  logic             acc_f;
  logic             same;
  logic             sat;
  logic             push;
  logic             pop;
  rec_t             push_rec;
  logic [REC_W-1:0] head;

  assign sample    = '{b32: in_b32, v33: in_v33, b34: in_b34};
  assign in_ready  = !full;
  assign acc_s     = in_valid && in_ready;
  assign acc_f     = flush && in_ready;
  assign same      = (sample == cur);
  assign sat       = (cnt == RUN_MAX);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head;

  // Push decode: at most one record leaves the encoder per cycle.
  always_comb begin
    push     = 1'b0;
    push_rec = '{sample: cur, cnt: cnt};
    if (state == ST_EMPTY) begin
      // A lone sample with flush is a complete run of one.
      if (acc_s && acc_f) begin
        push     = 1'b1;
        push_rec = '{sample: sample, cnt: CNT_ONE};
      end
    end else begin
      if (acc_s) begin
        if (!same || sat) begin
          push = 1'b1;
        end else if (acc_f) begin
          // Sample extends the run and the flush closes it in the same cycle.
          push     = 1'b1;
          push_rec = '{sample: cur, cnt: cnt + CNT_ONE};
        end
      end else if (acc_f) begin
        push = 1'b1;
      end
    end
  end

  // Run-length encoder state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc_s && !acc_f) begin
            cur   <= sample;
            cnt   <= CNT_ONE;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (acc_s) begin
            if (same && !sat) begin
              if (acc_f) state <= ST_EMPTY;
              else       cnt   <= cnt + CNT_ONE;
            end else begin
              // Different sample or saturated run: the sample opens a new run.
              cur <= sample;
              cnt <= CNT_ONE;
            end
          end else if (acc_f) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  mod29_sink_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef MOD29_SINK_STATS_EN
  // Wrapping count of every record pushed into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_count <= '0;
    else if (push) rec_count <= rec_count + 16'd1;
  end
`endif

endmodule : mod29_result_sink
